interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 28 ++
 rtl/irq_priority_enc.sv | 31 +++
 rtl/interrupt_controller.sv | 172 +++++++++++++++++
 tb/tb_interrupt_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// ---------------------------------------------------------------------------
// interrupt_controller_pkg
// Shared SoC definitions for the interrupt controller: local register
// addresses, CTRL/ACTIVE bit positions and the request FSM state encoding.
// ---------------------------------------------------------------------------
package interrupt_controller_pkg;

    // Local register map (2-bit address inside the IO window)
    localparam logic [1:0] ADDR_IE     = 2'd0;   // interrupt enable mask, R/W
    localparam logic [1:0] ADDR_PEND   = 2'd1;   // pending flags, read / write-1-to-clear
    localparam logic [1:0] ADDR_CTRL   = 2'd2;   // global control
    localparam logic [1:0] ADDR_ACTIVE = 2'd3;   // presented request status, read-only

    // CTRL register bits
    localparam int CTRL_GIE_BIT = 0;

    // ACTIVE register layout
    localparam int ACTIVE_BUSY_BIT = 7;
    localparam int ACTIVE_ID_MSB   = 2;

    // Request FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } irq_state_t;

endpackage : interrupt_controller_pkg

// File: rtl/irq_priority_enc.sv
// ---------------------------------------------------------------------------
// irq_priority_enc
// Combinational lowest-index-first priority encoder.
// Ports:
//   req   in  N  request vector (already masked by the caller)
//   id    out 3  index of the lowest set bit (0 when none set)
//   valid out 1  at least one request bit is set
// ---------------------------------------------------------------------------
module irq_priority_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [2:0]   id,
    output logic         valid
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise the tool infers a latch for it.
    always_comb begin
        id    = 3'd0;
        valid = 1'b0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule : irq_priority_enc

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Edge-triggered, maskable interrupt controller with a single presented
// request, fixed lowest-index priority and a vectored handler address.
// Ports:
//   clk       in   1        system clock, rising edge
//   reset     in   1        asynchronous active-high reset
//   irq_src   in   NUM_SRC  level request lines, 0->1 sets PEND
//   address   in   2        register select (IE, PEND, CTRL, ACTIVE)
//   din       in   8        register write data
//   w_en      in   1        register write strobe
//   r_en      in   1        register read strobe
//   dout      out  8        registered read data, valid the cycle after r_en
//   interrupt out  1        request to CPU, registered
//   intVect   out  16       handler address of the presented request
//   intAck    in   1        one-cycle CPU acknowledge
// ---------------------------------------------------------------------------
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_SRC     = 8,
    parameter logic [15:0] VECT_BASE   = 16'h0010,
    parameter int          VECT_STRIDE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [1:0]         address,
    input  logic [7:0]         din,
    input  logic               w_en,
    input  logic               r_en,
    output logic [7:0]         dout,
    output logic               interrupt,
    output logic [15:0]        intVect,
    input  logic               intAck
);

    logic [NUM_SRC-1:0] ie;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] irq_prev;
    logic               primed;      // first sample after reset taken
    logic               gie;
    logic [2:0]         id;
    irq_state_t         state;

    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] w1c_mask;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [2:0]         enc_id;
    logic               enc_valid;
    logic [15:0]        enc_vect;
    logic [7:0]         rd_data;
    logic               ack_take;

    // -----------------------------------------------------------------------
    // Priority selection among enabled pending sources
    // -----------------------------------------------------------------------
    irq_priority_enc #(
        .N (NUM_SRC)
    ) u_enc (
        .req   (pend & ie),
        .id    (enc_id),
        .valid (enc_valid)
    );

    // Vector arithmetic is done in 16 bits so any carry out is discarded.
    assign enc_vect = VECT_BASE + 16'(enc_id) * 16'(VECT_STRIDE);

    assign ack_take = (state == ST_REQ) && intAck;

    // -----------------------------------------------------------------------
    // Pending-flag next state. A new edge wins over a software clear or an
    // acknowledge in the same cycle so no request is ever lost. Edges are
    // ignored on the first cycle after reset so lines that were already high
    // must fall and rise again before they register.
    // -----------------------------------------------------------------------
    always_comb begin
        edge_det = primed ? (irq_src & ~irq_prev) : '0;
        w1c_mask = (w_en && (address == ADDR_PEND)) ? din[NUM_SRC-1:0] : '0;
        ack_clr  = ack_take ? (NUM_SRC'(1) << id) : '0;
        pend_nxt = (pend & ~w1c_mask & ~ack_clr) | edge_det;
    end

    // -----------------------------------------------------------------------
    // Read mux; upper IE/PEND bits beyond NUM_SRC read as zero.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        unique case (address)
            ADDR_IE:     rd_data = 8'(ie);
            ADDR_PEND:   rd_data = 8'(pend);
            ADDR_CTRL:   rd_data[CTRL_GIE_BIT] = gie;
            ADDR_ACTIVE: begin
                rd_data[ACTIVE_BUSY_BIT]    = (state != ST_IDLE);
                rd_data[ACTIVE_ID_MSB:0]    = id;
            end
            default:     rd_data = 8'h00;
        endcase
    end

    // -----------------------------------------------------------------------
    // Register file, edge samples and read port
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation ordering cannot matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie       <= '0;
            pend     <= '0;
            irq_prev <= '0;
            primed   <= 1'b0;
            gie      <= 1'b0;
            dout     <= 8'h00;
        end else begin
            irq_prev <= irq_src;
            primed   <= 1'b1;
            pend     <= pend_nxt;

            if (w_en && (address == ADDR_IE))
                ie <= din[NUM_SRC-1:0];

            // Acknowledge disarms the controller until the handler re-enables.
            if (ack_take)
                gie <= 1'b0;
            else if (w_en && (address == ADDR_CTRL))
                gie <= din[CTRL_GIE_BIT];

            if (r_en)
                dout <= rd_data;
        end
    end

    // -----------------------------------------------------------------------
    // Request FSM with registered outputs. Once in REQ the id and vector are
    // frozen; only intAck moves the FSM on. HOLD forces one low cycle on
    // interrupt between consecutive requests.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
            intVect   <= VECT_BASE;
            id        <= 3'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (gie && enc_valid) begin
                        state     <= ST_REQ;
                        id        <= enc_id;
                        intVect   <= enc_vect;
                        interrupt <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (intAck) begin
                        state     <= ST_HOLD;
                        interrupt <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule : interrupt_controller

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
// Directed self-checking bench for interrupt_controller.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  irq_src;
    logic [1:0]  address;
    logic [7:0]  din;
    logic        w_en;
    logic        r_en;
    logic [7:0]  dout;
    logic        interrupt;
    logic [15:0] intVect;
    logic        intAck;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    logic [7:0] rd;

    interrupt_controller #(
        .NUM_SRC     (8),
        .VECT_BASE   (16'h0010),
        .VECT_STRIDE (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .address   (address),
        .din       (din),
        .w_en      (w_en),
        .r_en      (r_en),
        .dout      (dout),
        .interrupt (interrupt),
        .intVect   (intVect),
        .intAck    (intAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the directed sequence is short, so this must never fire.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        address = a;
        din     = d;
        w_en    = 1'b1;
        step();
        w_en    = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        address = a;
        r_en    = 1'b1;
        step();
        r_en    = 1'b0;
        d       = dout;
    endtask

    task automatic ack();
        intAck = 1'b1;
        step();
        intAck = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        irq_src = 8'h00;
        address = 2'd0;
        din     = 8'h00;
        w_en    = 1'b0;
        r_en    = 1'b0;
        intAck  = 1'b0;

        // ---------------- reset state ----------------
        #23;
        check("rst_interrupt", 16'(interrupt), 16'h0000);
        check("rst_intvect",   intVect,        16'h0010);
        check("rst_dout",      16'(dout),      16'h0000);
        @(posedge clk); #2;
        reset = 1'b0;
        step();

        // ---------------- intAck in IDLE is ignored ----------------
        ack();
        check("idle_ack_interrupt", 16'(interrupt), 16'h0000);
        read_reg(ADDR_ACTIVE, rd);
        check("idle_ack_active", 16'(rd), 16'h0000);
        read_reg(ADDR_PEND, rd);
        check("idle_ack_pend", 16'(rd), 16'h0000);
        read_reg(ADDR_CTRL, rd);
        check("idle_ack_ctrl", 16'(rd), 16'h0000);

        // ---------------- single source 2 ----------------
        write_reg(ADDR_IE, 8'h05);
        write_reg(ADDR_CTRL, 8'h01);
        read_reg(ADDR_IE, rd);
        check("ie_readback", 16'(rd), 16'h0005);
        irq_src[2] = 1'b1;
        step();                      // PEND[2] set
        step();                      // FSM enters REQ
        check("src2_interrupt", 16'(interrupt), 16'h0001);
        check("src2_vect",      intVect,        16'h0018);
        read_reg(ADDR_ACTIVE, rd);
        check("src2_active", 16'(rd), 16'h0082);
        ack();
        check("src2_ack_interrupt", 16'(interrupt), 16'h0000);
        read_reg(ADDR_PEND, rd);
        check("src2_ack_pend", 16'(rd), 16'h0000);
        read_reg(ADDR_CTRL, rd);
        check("src2_ack_gie", 16'(rd), 16'h0000);
        irq_src[2] = 1'b0;
        step();

        // ---------------- simultaneous sources 1 and 3 ----------------
        write_reg(ADDR_IE, 8'hFF);
        write_reg(ADDR_CTRL, 8'h01);
        irq_src[1] = 1'b1;
        irq_src[3] = 1'b1;
        step();
        step();
        check("prio_first_interrupt", 16'(interrupt), 16'h0001);
        check("prio_first_vect",      intVect,        16'h0014);
        ack();
        check("prio_first_ack_interrupt", 16'(interrupt), 16'h0000);
        read_reg(ADDR_PEND, rd);
        check("prio_pend_after_ack", 16'(rd), 16'h0008);
        write_reg(ADDR_CTRL, 8'h01);
        step();
        check("prio_second_interrupt", 16'(interrupt), 16'h0001);
        check("prio_second_vect",      intVect,        16'h001C);
        ack();
        irq_src[1] = 1'b0;
        irq_src[3] = 1'b0;
        read_reg(ADDR_PEND, rd);
        check("prio_pend_empty", 16'(rd), 16'h0000);

        // ---------------- W1C racing a new edge ----------------
        irq_src[0] = 1'b1;
        write_reg(ADDR_PEND, 8'h01);
        read_reg(ADDR_PEND, rd);
        check("w1c_race_pend", 16'(rd), 16'h0001);
        write_reg(ADDR_PEND, 8'h01);
        read_reg(ADDR_PEND, rd);
        check("w1c_clear_pend", 16'(rd), 16'h0000);
        irq_src[0] = 1'b0;
        step();

        // ---------------- REQ does not retract ----------------
        write_reg(ADDR_CTRL, 8'h01);
        irq_src[5] = 1'b1;
        step();
        step();
        check("frozen_vect_initial", intVect, 16'h0024);
        write_reg(ADDR_IE, 8'h00);
        write_reg(ADDR_CTRL, 8'h00);
        step();
        check("frozen_interrupt", 16'(interrupt), 16'h0001);
        check("frozen_vect",      intVect,        16'h0024);
        ack();
        check("frozen_ack_interrupt", 16'(interrupt), 16'h0000);
        irq_src[5] = 1'b0;
        step();

        // ---------------- reset mid-REQ with source held high ----------------
        write_reg(ADDR_IE, 8'h10);
        write_reg(ADDR_CTRL, 8'h01);
        irq_src[4] = 1'b1;
        step();
        step();
        check("rstreq_interrupt_before", 16'(interrupt), 16'h0001);
        check("rstreq_vect_before",      intVect,        16'h0020);
        #2;
        reset = 1'b1;
        #1;
        check("rstreq_interrupt_async", 16'(interrupt), 16'h0000);
        check("rstreq_vect_async",      intVect,        16'h0010);
        step();
        #2;
        reset = 1'b0;
        write_reg(ADDR_IE, 8'hFF);
        write_reg(ADDR_CTRL, 8'h01);
        step();
        step();
        read_reg(ADDR_PEND, rd);
        check("rstreq_pend_held", 16'(rd), 16'h0000);
        check("rstreq_no_interrupt", 16'(interrupt), 16'h0000);
        irq_src[4] = 1'b0;
        step();
        irq_src[4] = 1'b1;
        step();                      // PEND[4] set
        read_reg(ADDR_PEND, rd);     // FSM enters REQ at this edge
        check("rstreq_pend_retoggle", 16'(rd), 16'h0010);
        check("rstreq_interrupt_again", 16'(interrupt), 16'h0001);
        check("rstreq_vect_again",      intVect,        16'h0020);
        ack();
        check("rstreq_ack_interrupt", 16'(interrupt), 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule : tb_interrupt_controller
